// File: rtl/serial_paralelo_rx.sv
// Rx serial-to-parallel converter: hunts for the COM symbol to find byte boundaries,
// declares the link active after COM_NEEDED aligned COMs, then emits data bytes.
module serial_paralelo_rx #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         COM_NEEDED = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {ST_SEARCH, ST_ALIGNED, ST_ACTIVE} state_t;

  localparam logic [2:0] NEED = 3'(COM_NEEDED);

  state_t     state, state_nxt;
  logic [6:0] sr;
  logic [7:0] win;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [2:0] com_cnt, com_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, active_nxt;
  logic       is_com, boundary;

  assign win      = {sr, data_in};
  assign is_com   = (win == COM);
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= ST_SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= win[6:0];
      bit_cnt   <= bit_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      active    <= active_nxt;
    end
  end

  // The bit counter idles in SEARCH; a COM hit there marks the current edge as a boundary.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    com_cnt_nxt = com_cnt;
    case (state)
      ST_SEARCH: begin
        if (is_com) begin
          bit_cnt_nxt = 3'd0;
          com_cnt_nxt = 3'd1;
          state_nxt   = (NEED == 3'd1) ? ST_ACTIVE : ST_ALIGNED;
        end
      end
      ST_ALIGNED: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_nxt = com_cnt + 3'd1;
            if (com_cnt + 3'd1 == NEED) state_nxt = ST_ACTIVE;
          end else begin
            com_cnt_nxt = 3'd0;
            state_nxt   = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: bit_cnt_nxt = bit_cnt + 3'd1;
      default:   state_nxt   = ST_SEARCH;
    endcase
  end

  // Outputs move only at byte boundaries so each value is stable for a full byte period.
  always_comb begin
    data_nxt   = data_out;
    valid_nxt  = valid_out;
    active_nxt = (state_nxt == ST_ACTIVE);
    if (state == ST_ACTIVE && boundary) begin
      if (is_com) begin
        valid_nxt = 1'b0;
      end else begin
        data_nxt  = win;
        valid_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: expected {active,valid,data} per byte are queued
// as bytes are driven and checked at the boundary; outputs are checked to hold in between.
module tb_serial_paralelo_rx;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  logic [9:0] cur;
  logic [9:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  serial_paralelo_rx #(.COM(8'hBC), .COM_NEEDED(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  function automatic logic [9:0] obs();
    return {active, valid_out, data_out};
  endfunction

  task automatic chk(input string tag, input logic [9:0] e);
    logic [9:0] o;
    o = obs();
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed act/vld/data=%b/%b/%h expected %b/%b/%h",
             tag, o[9], o[8], o[7:0], e[9], e[8], e[7:0]);
    end
  endtask

  // One negedge: pop a pending boundary expectation, otherwise require the outputs to hold.
  task automatic tick_check();
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("boundary", cur);
    end else begin
      chk("hold", cur);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    tick_check();
    data_in = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ea, input logic ev, input logic [7:0] ed);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    exp_q.push_back({ea, ev, ed});
  endtask

  task automatic flush();
    @(negedge clk_32f);
    tick_check();
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_32f);
      data_in = 1'($urandom);
      chk("reset", 10'h000);
    end
    reset   = 1'b0;
    data_in = 1'b0;
    cur     = '0;
    exp_q.delete();
  endtask

  task automatic com_run(input int n, input logic last_active);
    for (int i = 0; i < n; i++)
      send_byte(8'hBC, (i == n - 1) ? last_active : 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    cur = '0;

    // Reset with random line data
    do_reset();

    // Aligned start
    com_run(4, 1'b1);
    send_byte(8'h5A, 1'b1, 1'b1, 8'h5A);
    send_byte(8'hC3, 1'b1, 1'b1, 8'hC3);
    flush();

    // Misaligned start: 3 junk bits ahead of the COM run
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    com_run(4, 1'b1);
    send_byte(8'h12, 1'b1, 1'b1, 8'h12);
    flush();

    // Broken COM run
    do_reset();
    com_run(3, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0, 8'h00);
    com_run(4, 1'b1);
    send_byte(8'h7E, 1'b1, 1'b1, 8'h7E);
    flush();

    // Idle COMs while active
    do_reset();
    com_run(4, 1'b1);
    send_byte(8'h33, 1'b1, 1'b1, 8'h33);
    send_byte(8'hBC, 1'b1, 1'b0, 8'h33);
    send_byte(8'hBC, 1'b1, 1'b0, 8'h33);
    send_byte(8'h44, 1'b1, 1'b1, 8'h44);
    flush();

    // Reset pulse in the middle of an active data byte
    do_reset();
    com_run(4, 1'b1);
    send_byte(8'h66, 1'b1, 1'b1, 8'h66);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    @(posedge clk_32f);
    #2 reset = 1'b1;
    #1 chk("async_clear", 10'h000);
    @(negedge clk_32f);
    chk("reset_held", 10'h000);
    reset   = 1'b0;
    data_in = 1'b0;
    cur     = '0;
    exp_q.delete();
    com_run(4, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b1, 8'hA5);
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
